// File: rtl/ifu_prefetch_if.sv
// ifu_prefetch bus types and interface.
//   ifu_prefetch_pkg : ibus_req_t {valid, addr[63:0]}, ibus_resp_t {data_ok, data[31:0]}
//   ifu_prefetch_if  : groups the instruction-bus request/response, the redirect
//                      input and the decode-side queue port.
//     master modport (prefetcher): drives ireq, out_valid, out_pc, out_instr, fq_count;
//                                  samples iresp, redirect_valid, pc_target, out_ready.
//     slave modport  (environment): the mirror image.
package ifu_prefetch_pkg;
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;
endpackage

interface ifu_prefetch_if #(
  parameter int DEPTH = 4
);
  import ifu_prefetch_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  ibus_req_t        ireq;
  ibus_resp_t       iresp;
  logic             redirect_valid;
  logic [63:0]      pc_target;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_pc;
  logic [31:0]      out_instr;
  logic [CW-1:0]    fq_count;

  modport master (
    output ireq,
    input  iresp,
    input  redirect_valid,
    input  pc_target,
    output out_valid,
    input  out_ready,
    output out_pc,
    output out_instr,
    output fq_count
  );

  modport slave (
    input  ireq,
    output iresp,
    output redirect_valid,
    output pc_target,
    input  out_valid,
    output out_ready,
    input  out_pc,
    input  out_instr,
    input  fq_count
  );
endinterface

// File: rtl/ifu_prefetch.sv
// ifu_prefetch: instruction prefetcher with a DEPTH-entry fetch queue.
//   clk, rst   : single clock, asynchronous active-high reset.
//   bus.ireq   : one outstanding instruction request (valid held until data_ok).
//   bus.iresp  : response; data pushed into the queue with its PC.
//   bus.redirect_valid / pc_target : flush queue, refetch from pc_target.
//   bus.out_*  : head of queue toward decode (valid/ready), fq_count = occupancy.
// A request is only issued when a queue slot is guaranteed, so a response in
// WAIT can always be pushed. Redirects that land while a request is in flight
// move to DROP, which lets that request finish and throws its data away.
module ifu_prefetch
  import ifu_prefetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input logic            clk,
  input logic            rst,
  ifu_prefetch_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  logic [1:0]    state_r, state_s;
  logic          req_valid_r;
  logic [63:0]   fetch_pc_r, fetch_pc_s;
  logic [63:0]   req_addr_r, req_addr_s;
  logic [PW-1:0] head_r, head_s;
  logic [PW-1:0] tail_r, tail_s;
  logic [CW-1:0] count_r, count_s;
  logic [63:0]   pc_mem_r    [DEPTH];
  logic [31:0]   instr_mem_r [DEPTH];

  logic          resp_ok_s;
  logic          pop_s;
  logic          push_s;
  logic [CW-1:0] cnt_pop_s;
  logic [CW-1:0] cnt_push_s;

  // Responses only count while a request is actually outstanding.
  assign resp_ok_s  = bus.iresp.data_ok && ((state_r == S_WAIT) || (state_r == S_DROP));
  // A redirect overrides the pop; the queue is emptied instead.
  assign pop_s      = (count_r != {CW{1'b0}}) && bus.out_ready && !bus.redirect_valid;
  assign cnt_pop_s  = count_r - {{(CW-1){1'b0}}, pop_s};
  assign cnt_push_s = cnt_pop_s + {{(CW-1){1'b0}}, 1'b1};

  // Next-state logic for the fetch FSM and queue pointers.
  always_comb begin
    state_s    = state_r;
    fetch_pc_s = fetch_pc_r;
    req_addr_s = req_addr_r;
    head_s     = head_r;
    tail_s     = tail_r;
    count_s    = count_r;
    push_s     = 1'b0;

    if (bus.redirect_valid) begin
      head_s     = {PW{1'b0}};
      tail_s     = {PW{1'b0}};
      count_s    = {CW{1'b0}};
      fetch_pc_s = bus.pc_target;
      if ((state_r == S_IDLE) || resp_ok_s) begin
        state_s    = S_WAIT;
        req_addr_s = bus.pc_target;
      end else begin
        // In-flight request cannot be retracted; wait it out and discard.
        state_s = S_DROP;
      end
    end else begin
      head_s  = head_r + {{(PW-1){1'b0}}, pop_s};
      count_s = cnt_pop_s;
      case (state_r)
        S_IDLE: begin
          if (cnt_pop_s < DEPTH_C) begin
            state_s    = S_WAIT;
            req_addr_s = fetch_pc_r;
          end else begin
            state_s = S_IDLE;
          end
        end
        S_WAIT: begin
          if (resp_ok_s) begin
            push_s     = 1'b1;
            tail_s     = tail_r + {{(PW-1){1'b0}}, 1'b1};
            count_s    = cnt_push_s;
            fetch_pc_s = req_addr_r + 64'd4;
            if (cnt_push_s < DEPTH_C) begin
              // Slot still free after this push: issue the next word immediately.
              req_addr_s = req_addr_r + 64'd4;
            end else begin
              state_s = S_IDLE;
            end
          end else begin
            state_s = S_WAIT;
          end
        end
        S_DROP: begin
          if (resp_ok_s) begin
            state_s    = S_WAIT;
            req_addr_s = fetch_pc_r;
          end else begin
            state_s = S_DROP;
          end
        end
        default: begin
          state_s = S_IDLE;
        end
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_IDLE;
      req_valid_r <= 1'b0;
      fetch_pc_r  <= RESET_PC;
      req_addr_r  <= RESET_PC;
      head_r      <= {PW{1'b0}};
      tail_r      <= {PW{1'b0}};
      count_r     <= {CW{1'b0}};
    end else begin
      state_r     <= state_s;
      req_valid_r <= (state_s != S_IDLE);
      fetch_pc_r  <= fetch_pc_s;
      req_addr_r  <= req_addr_s;
      head_r      <= head_s;
      tail_r      <= tail_s;
      count_r     <= count_s;
    end
  end

  // Queue storage; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      pc_mem_r[tail_r]    <= req_addr_r;
      instr_mem_r[tail_r] <= bus.iresp.data;
    end
  end

  assign bus.ireq.valid = req_valid_r;
  assign bus.ireq.addr  = req_addr_r;
  assign bus.out_valid  = (count_r != {CW{1'b0}});
  assign bus.out_pc     = pc_mem_r[head_r];
  assign bus.out_instr  = instr_mem_r[head_r];
  assign bus.fq_count   = count_r;

endmodule

// File: tb/tb_ifu_prefetch.sv
// Self-checking bench for ifu_prefetch: a vector table for queue fill/drain
// timing plus hand-written redirect/reset sequences; delivered instructions are
// compared against a queue of expected {pc, instr} pairs.
module tb_ifu_prefetch;
  localparam logic [63:0] R = 64'h0000_0000_8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ok_en = 1'b0;
  logic sb_en = 1'b0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic        rdy;
    logic        ok;
    logic        exp_valid;
    logic [63:0] exp_addr;
    logic [63:0] exp_count;
    logic        exp_ov;
    logic [63:0] exp_pc;
  } vec_t;

  vec_t        vecs [12];
  logic [63:0] sb_q [$];

  ifu_prefetch_if #(.DEPTH(4)) bus ();

  ifu_prefetch #(.DEPTH(4), .RESET_PC(R)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return {a[15:0], a[31:16]} ^ a[63:32] ^ 32'hC0DE_5A5A;
  endfunction

  // Memory model: answers whenever enabled and a request is up.
  assign bus.iresp = {ok_en & bus.ireq.valid, instr_of(bus.ireq.addr)};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_stream(input logic [63:0] base);
    sb_q.delete();
    for (int i = 0; i < 40; i++) sb_q.push_back(base + 64'(4 * i));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_ireq_valid", {63'd0, bus.ireq.valid}, 64'd0);
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_fq_count", 64'(bus.fq_count), 64'd0);
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Scoreboard: every head accepted by decode must match the next expected PC.
  always @(negedge clk) begin
    logic [63:0] e;
    #2;
    if (sb_en && !rst && !bus.redirect_valid && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected actual=%h expected=none", bus.out_pc);
      end else begin
        e = sb_q.pop_front();
        chk("sb_pc", bus.out_pc, e);
        chk("sb_instr", 64'(bus.out_instr), 64'(instr_of(e)));
      end
    end
  end

  initial begin
    logic [63:0] old_addr;
    logic [63:0] tgt;

    vecs[0]  = '{1'b0, 1'b1, 1'b1, R,          64'd0, 1'b0, 64'd0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, R + 64'h4,  64'd1, 1'b1, R};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, R + 64'h8,  64'd2, 1'b1, R};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, R + 64'hC,  64'd3, 1'b1, R};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 64'd0,      64'd4, 1'b1, R};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 64'd0,      64'd4, 1'b1, R};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, R + 64'h10, 64'd3, 1'b1, R + 64'h4};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 64'd0,      64'd4, 1'b1, R + 64'h4};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, R + 64'h14, 64'd3, 1'b1, R + 64'h8};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, R + 64'h14, 64'd3, 1'b1, R + 64'h8};
    vecs[10] = '{1'b1, 1'b1, 1'b1, R + 64'h18, 64'd3, 1'b1, R + 64'hC};
    vecs[11] = '{1'b1, 1'b1, 1'b1, R + 64'h1C, 64'd3, 1'b1, R + 64'h10};

    bus.redirect_valid = 1'b0;
    bus.pc_target      = 64'd0;
    bus.out_ready      = 1'b0;

    // Fill to full, stall, single pop, then streaming with simultaneous push/pop.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      bus.out_ready = vecs[i].rdy;
      ok_en         = vecs[i].ok;
      cyc();
      chk($sformatf("vec%0d_ireq_valid", i), {63'd0, bus.ireq.valid}, {63'd0, vecs[i].exp_valid});
      if (vecs[i].exp_valid) chk($sformatf("vec%0d_ireq_addr", i), bus.ireq.addr, vecs[i].exp_addr);
      chk($sformatf("vec%0d_fq_count", i), 64'(bus.fq_count), vecs[i].exp_count);
      chk($sformatf("vec%0d_out_valid", i), {63'd0, bus.out_valid}, {63'd0, vecs[i].exp_ov});
      if (vecs[i].exp_ov) begin
        chk($sformatf("vec%0d_out_pc", i), bus.out_pc, vecs[i].exp_pc);
        chk($sformatf("vec%0d_out_instr", i), 64'(bus.out_instr), 64'(instr_of(vecs[i].exp_pc)));
      end
      #1;
    end

    // Back-to-back fetch after reset with decode always ready.
    bus.out_ready = 1'b1;
    ok_en         = 1'b1;
    load_stream(R);
    sb_en = 1'b1;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("b2b_ireq_valid", {63'd0, bus.ireq.valid}, 64'd1);
      chk("b2b_ireq_addr", bus.ireq.addr, R + 64'(4 * k));
      if (k > 0) chk("b2b_out_pc", bus.out_pc, R + 64'(4 * (k - 1)));
      #1;
    end
    repeat (5) begin cyc(); #1; end

    // Redirect while a request is stalled; its late response must be dropped.
    ok_en = 1'b0;
    cyc();
    #1;
    old_addr = bus.ireq.addr;
    tgt = 64'h0000_0000_8000_1000;
    bus.redirect_valid = 1'b1;
    bus.pc_target      = tgt;
    load_stream(tgt);
    cyc();
    chk("drop_fq_count", 64'(bus.fq_count), 64'd0);
    chk("drop_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("drop_ireq_valid", {63'd0, bus.ireq.valid}, 64'd1);
    chk("drop_ireq_addr_held", bus.ireq.addr, old_addr);
    #1;
    bus.redirect_valid = 1'b0;
    cyc(); #1;
    cyc(); #1;
    ok_en = 1'b1;
    cyc();
    chk("drop_refetch_addr", bus.ireq.addr, tgt);
    chk("drop_refetch_count", 64'(bus.fq_count), 64'd0);
    #1;
    cyc();
    chk("drop_first_out_pc", bus.out_pc, tgt);
    chk("drop_first_out_valid", {63'd0, bus.out_valid}, 64'd1);
    #1;
    repeat (4) begin cyc(); #1; end

    // Redirect coinciding with a response and a pop.
    tgt = 64'h0000_0000_4000_0000;
    bus.redirect_valid = 1'b1;
    bus.pc_target      = tgt;
    load_stream(tgt);
    cyc();
    chk("coinc_fq_count", 64'(bus.fq_count), 64'd0);
    chk("coinc_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("coinc_ireq_addr", bus.ireq.addr, tgt);
    #1;
    bus.redirect_valid = 1'b0;
    repeat (5) begin cyc(); #1; end

    // Two redirects while dropping: only the last target is fetched.
    ok_en = 1'b0;
    cyc(); #1;
    bus.redirect_valid = 1'b1;
    bus.pc_target      = 64'h100;
    load_stream(64'h100);
    cyc();
    chk("dbl_first_count", 64'(bus.fq_count), 64'd0);
    #1;
    bus.pc_target = 64'h200;
    load_stream(64'h200);
    cyc();
    chk("dbl_second_count", 64'(bus.fq_count), 64'd0);
    chk("dbl_second_valid", {63'd0, bus.ireq.valid}, 64'd1);
    #1;
    bus.redirect_valid = 1'b0;
    ok_en = 1'b1;
    cyc();
    chk("dbl_refetch_addr", bus.ireq.addr, 64'h200);
    #1;
    cyc();
    chk("dbl_first_out_pc", bus.out_pc, 64'h200);
    #1;
    repeat (4) begin cyc(); #1; end

    // Reset with three queued entries and a request outstanding.
    sb_en = 1'b0;
    bus.out_ready = 1'b0;
    do_reset();
    repeat (4) cyc();
    chk("mid_pre_count", 64'(bus.fq_count), 64'd3);
    chk("mid_pre_valid", {63'd0, bus.ireq.valid}, 64'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_ireq_valid", {63'd0, bus.ireq.valid}, 64'd0);
    chk("mid_rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("mid_rst_count", 64'(bus.fq_count), 64'd0);
    repeat (2) cyc();
    chk("mid_rst_hold_valid", {63'd0, bus.ireq.valid}, 64'd0);
    chk("mid_rst_hold_count", 64'(bus.fq_count), 64'd0);
    #1;
    rst = 1'b0;
    cyc();
    chk("mid_restart_valid", {63'd0, bus.ireq.valid}, 64'd1);
    chk("mid_restart_addr", bus.ireq.addr, R);
    chk("mid_restart_count", 64'(bus.fq_count), 64'd0);
    #1;
    cyc();
    chk("mid_restart_out_pc", bus.out_pc, R);
    chk("mid_restart_count1", 64'(bus.fq_count), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ifu_prefetch.md
IFU_PREFETCH -- requirements
Module: ifu_prefetch

Interface
REQ-001 Parameter DEPTH, default 4, fetch-queue entries; power of two, >= 2.
REQ-002 Parameter RESET_PC, default 64'h0000_0000_8000_0000, first fetch address.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 ireq  output  ibus_req_t  instruction bus request: valid (1), addr (64).
REQ-006 iresp  input  ibus_resp_t  instruction bus response: data_ok (1), data (32).
REQ-007 redirect_valid  input  1  flush queue and refetch from pc_target.
REQ-008 pc_target  input  64  redirect address.
REQ-009 out_valid  output  1  queue head valid toward decode.
REQ-010 out_ready  input  1  decode accepts head.
REQ-011 out_pc  output  64  PC of queue head.
REQ-012 out_instr  output  32  instruction of queue head.
REQ-013 fq_count  output  $clog2(DEPTH)+1  current queue occupancy.

Function
REQ-014 Block SHALL hold a circular FIFO of DEPTH entries {pc[63:0], instr[31:0]}, head/tail pointers wrapping modulo DEPTH, and occupancy count.
REQ-015 out_valid SHALL equal (count != 0); out_pc/out_instr SHALL come combinationally from the head entry.
REQ-016 Pop SHALL occur when out_valid && out_ready; push SHALL occur only as defined in REQ-021; simultaneous push and pop SHALL leave count unchanged.
REQ-017 FSM states SHALL be IDLE (no request), WAIT (live request outstanding), DROP (stale request outstanding, response discarded).
REQ-018 ireq.valid SHALL be 1 exactly in WAIT and DROP, driven from registered state; ireq.addr SHALL equal register req_addr.
REQ-019 At most one request SHALL be outstanding; ireq.valid and ireq.addr SHALL stay constant until the cycle iresp.data_ok=1.
REQ-020 IDLE, no redirect: if count_next < DEPTH, go WAIT, req_addr <= fetch_pc; else stay IDLE (count_next = count after this cycle's pop).
REQ-021 WAIT, data_ok=1, no redirect: push {req_addr, iresp.data}; fetch_pc <= req_addr+4; if count_next (after push and pop) < DEPTH stay WAIT with req_addr <= req_addr+4 (back-to-back, no bubble), else go IDLE.
REQ-022 WAIT, data_ok=0, no redirect: hold.
REQ-023 DROP, data_ok=1, no redirect: discard data, no push, go WAIT with req_addr <= fetch_pc.
REQ-024 Redirect (any state) SHALL take priority over push and pop: count, head, tail <= 0; fetch_pc <= pc_target.
REQ-025 Redirect in IDLE, or in WAIT/DROP with data_ok=1: response (if any) discarded; go WAIT, req_addr <= pc_target.
REQ-026 Redirect in WAIT/DROP with data_ok=0: go DROP, req_addr unchanged (in-flight request completes unretracted).
REQ-027 Address arithmetic SHALL be 64-bit modulo 2^64; +4 wraps silently.
REQ-028 Queue full (count==DEPTH) SHALL never receive a push; FSM guarantees this by issuing only when a slot is reserved.

Reset
REQ-029 On rst=1, asynchronously: state IDLE, fetch_pc=RESET_PC, req_addr=RESET_PC, head=tail=count=0; therefore ireq.valid=0, out_valid=0, fq_count=0.
REQ-030 Reset asserted mid-request SHALL abandon the outstanding request; any data_ok while rst=1 SHALL be ignored.
REQ-031 First rising edge after rst deasserts SHALL move IDLE->WAIT; ireq.valid=1, ireq.addr=RESET_PC from that cycle.

Verification
REQ-032 Reset release, bus data_ok every cycle, out_ready=1 -> ireq.addr 0x8000_0000, 0x8000_0004, 0x8000_0008 on consecutive cycles; out_pc follows one cycle later each.
REQ-033 out_ready=0, DEPTH=4, data_ok always 1 -> exactly 4 pushes, fq_count=4, ireq.valid=0; one pop -> ireq.valid=1 next cycle at addr 0x8000_0010.
REQ-034 Redirect to 0x8000_1000 while WAIT with data_ok=0, response arrives 3 cycles later -> fq_count=0, that data never appears at out, next ireq.addr=0x8000_1000.
REQ-035 Redirect coinciding with data_ok=1 and pop -> no push, fq_count=0, next ireq.addr=pc_target.
REQ-036 Two redirects (0x100 then 0x200) while DROP -> only 0x200 fetched; first out_pc=0x200.
REQ-037 rst asserted with 3 queued entries and a request outstanding -> outputs at reset values immediately, restart at RESET_PC.
